// File: rtl/contrast_lut_pkg.sv
// -----------------------------------------------------------------------------
// contrast_lut_pkg
//   Shared types and constants for the contrast curve controller.
//   Optional build macro used by contrast_lut_ctrl: CONTRAST_LUT_READBACK_EN.
// -----------------------------------------------------------------------------
package contrast_lut_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 256;
   localparam int unsigned PIPE_LAT   = 2;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_LOAD,
      ST_PENDING
   } lut_state_e;

   typedef logic [7:0] gray_t;

   // Frame start as seen on the input side: vsync low last cycle, high now.
   function automatic logic vsync_rise(input logic prev_vsync, input logic cur_vsync);
      return cur_vsync & ~prev_vsync;
   endfunction

endpackage

// File: rtl/contrast_lut_bank.sv
// -----------------------------------------------------------------------------
// contrast_lut_bank
//   One curve table: DEPTH x DATA_W RAM, one write port, one synchronous read
//   port. A read and a write to the same address in the same cycle return the
//   old contents.
// Ports:
//   clk        system clock
//   i_wr_en    write strobe
//   i_wr_addr  write address
//   i_wr_data  write data
//   i_rd_addr  read address (sampled every cycle)
//   o_rd_data  registered read data, valid one cycle after i_rd_addr
// -----------------------------------------------------------------------------
module contrast_lut_bank #(
   parameter  int unsigned DATA_W = 8,
   localparam int unsigned DEPTH  = 2**DATA_W
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [DATA_W-1:0] i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [DATA_W-1:0] i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

// File: rtl/contrast_lut_ctrl.sv
// -----------------------------------------------------------------------------
// contrast_lut_ctrl
//   Maps a vsync/href/gray video stream through one of two 256-entry contrast
//   curves (ping-pong banks). The host fills the shadow bank and commits; the
//   banks swap on the next input frame start so no frame mixes two curves.
//   After reset both banks are filled with the identity curve (256 cycles).
//   Fixed 2-cycle pixel latency.
//
//   Build macro CONTRAST_LUT_READBACK_EN adds shadow-bank readback
//   (cfg_rd_en / cfg_rd_data).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   per_img_vsync/href  input frame / pixel valid
//   per_img_gray        input pixel
//   cfg_wr_en           shadow-bank write strobe (LOAD only)
//   cfg_addr, cfg_data  shadow-bank write address / data
//   cfg_commit          request bank swap at next frame start (LOAD only)
//   cfg_rd_en           [readback] shadow-bank read strobe (LOAD only)
//   cfg_rd_data         [readback] read data, one cycle after cfg_rd_en
//   cfg_busy            high in INIT and PENDING
//   active_bank         bank used for mapping
//   post_img_vsync/href inputs delayed 2 cycles
//   post_img_gray       mapped pixel, 0 when post_img_href is low
// -----------------------------------------------------------------------------
module contrast_lut_ctrl
   import contrast_lut_pkg::*;
#(
   parameter  int unsigned DATA_W = DATA_W_DEF,
   localparam int unsigned DEPTH  = 2**DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_img_vsync,
   input  logic              per_img_href,
   input  logic [DATA_W-1:0] per_img_gray,
   input  logic              cfg_wr_en,
   input  logic [DATA_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              cfg_commit,
`ifdef CONTRAST_LUT_READBACK_EN
   input  logic              cfg_rd_en,
   output logic [DATA_W-1:0] cfg_rd_data,
`endif
   output logic              cfg_busy,
   output logic              active_bank,
   output logic              post_img_vsync,
   output logic              post_img_href,
   output logic [DATA_W-1:0] post_img_gray
);

   // --------------------------------------------------------------------------
   // Control state
   // --------------------------------------------------------------------------
   lut_state_e        r_state;
   lut_state_e        w_state_nxt;
   logic [DATA_W-1:0] r_init_cnt;
   logic              r_active;
   logic              w_swap;
   logic              w_cfg_wr;

   // --------------------------------------------------------------------------
   // Pipeline
   // --------------------------------------------------------------------------
   logic              r_vsync_s1;
   logic              r_href_s1;
   logic [DATA_W-1:0] r_gray_s1;
   logic              r_vsync_s2;
   logic              r_href_s2;
   logic              r_sel_s2;

   // --------------------------------------------------------------------------
   // Bank ports
   // --------------------------------------------------------------------------
   logic              w_init;
   logic              w_bank0_we;
   logic              w_bank1_we;
   logic [DATA_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [DATA_W-1:0] w_rd_addr0;
   logic [DATA_W-1:0] w_rd_addr1;
   logic [DATA_W-1:0] w_rd_data0;
   logic [DATA_W-1:0] w_rd_data1;

   // --------------------------------------------------------------------------
   // FSM: next state
   // --------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_swap      = 1'b0;
      w_cfg_wr    = 1'b0;
      case (r_state)
         ST_INIT: begin
            if (r_init_cnt == DATA_W'(DEPTH - 1)) begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_LOAD: begin
            // A write in the commit cycle still lands before the FSM leaves LOAD.
            w_cfg_wr = cfg_wr_en;
            if (cfg_commit) begin
               w_state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (vsync_rise(r_vsync_s1, per_img_vsync)) begin
               w_swap      = 1'b1;
               w_state_nxt = ST_LOAD;
            end
         end
         default: begin
            w_state_nxt = ST_INIT;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // FSM: state register, init counter, active bank
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_INIT;
         r_init_cnt <= '0;
         r_active   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_INIT) begin
            r_init_cnt <= r_init_cnt + 1'b1;
         end
         // Toggling on the vsync-rise cycle lets the first pixel of the new
         // frame, read one cycle later in stage 2, see the new bank.
         if (w_swap) begin
            r_active <= ~r_active;
         end
      end
   end

   // --------------------------------------------------------------------------
   // Write-port mux: INIT fills both banks with identity; LOAD writes only the
   // shadow bank, so the active bank can never be written by the host.
   // --------------------------------------------------------------------------
   always_comb begin
      w_init     = (r_state == ST_INIT);
      w_wr_addr  = w_init ? r_init_cnt : cfg_addr;
      w_wr_data  = w_init ? r_init_cnt : cfg_data;
      w_bank0_we = w_init | (w_cfg_wr &  r_active);
      w_bank1_we = w_init | (w_cfg_wr & ~r_active);
   end

   // --------------------------------------------------------------------------
   // Pixel pipeline
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_s1 <= 1'b0;
         r_href_s1  <= 1'b0;
         r_gray_s1  <= '0;
         r_vsync_s2 <= 1'b0;
         r_href_s2  <= 1'b0;
         r_sel_s2   <= 1'b0;
      end else begin
         r_vsync_s1 <= per_img_vsync;
         r_href_s1  <= per_img_href;
         r_gray_s1  <= per_img_gray;
         r_vsync_s2 <= r_vsync_s1;
         r_href_s2  <= r_href_s1;
         // Remembers which bank produced this cycle's RAM read data.
         r_sel_s2   <= r_active;
      end
   end

`ifdef CONTRAST_LUT_READBACK_EN
   // The shadow bank's read port is free of pixel traffic, so it serves the
   // host readback.
   logic              r_rd_vld;
   logic              r_rd_bank;
   logic [DATA_W-1:0] r_rd_hold;

   assign w_rd_addr0 = r_active ? cfg_addr  : r_gray_s1;
   assign w_rd_addr1 = r_active ? r_gray_s1 : cfg_addr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_vld  <= 1'b0;
         r_rd_bank <= 1'b0;
         r_rd_hold <= '0;
      end else begin
         r_rd_vld  <= (r_state == ST_LOAD) & cfg_rd_en;
         r_rd_bank <= ~r_active;
         if (r_rd_vld) begin
            r_rd_hold <= cfg_rd_data;
         end
      end
   end

   // Fresh RAM data in the cycle after a read, held value otherwise.
   assign cfg_rd_data = r_rd_vld ? (r_rd_bank ? w_rd_data1 : w_rd_data0) : r_rd_hold;
`else
   assign w_rd_addr0 = r_gray_s1;
   assign w_rd_addr1 = r_gray_s1;
`endif

   // --------------------------------------------------------------------------
   // Banks
   // --------------------------------------------------------------------------
   contrast_lut_bank #(
      .DATA_W (DATA_W)
   ) u_bank0 (
      .clk       (clk),
      .i_wr_en   (w_bank0_we),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_wr_data),
      .i_rd_addr (w_rd_addr0),
      .o_rd_data (w_rd_data0)
   );

   contrast_lut_bank #(
      .DATA_W (DATA_W)
   ) u_bank1 (
      .clk       (clk),
      .i_wr_en   (w_bank1_we),
      .i_wr_addr (w_wr_addr),
      .i_wr_data (w_wr_data),
      .i_rd_addr (w_rd_addr1),
      .o_rd_data (w_rd_data1)
   );

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign cfg_busy       = (r_state != ST_LOAD);
   assign active_bank    = r_active;
   assign post_img_vsync = r_vsync_s2;
   assign post_img_href  = r_href_s2;
   assign post_img_gray  = r_href_s2 ? (r_sel_s2 ? w_rd_data1 : w_rd_data0) : '0;

endmodule

// File: tb/tb_contrast_lut_ctrl.sv
module tb_contrast_lut_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       per_img_vsync = 1'b0;
   logic       per_img_href = 1'b0;
   logic [7:0] per_img_gray = '0;
   logic       cfg_wr_en = 1'b0;
   logic [7:0] cfg_addr = '0;
   logic [7:0] cfg_data = '0;
   logic       cfg_commit = 1'b0;
   logic       cfg_busy;
   logic       active_bank;
   logic       post_img_vsync;
   logic       post_img_href;
   logic [7:0] post_img_gray;
`ifdef CONTRAST_LUT_READBACK_EN
   logic       cfg_rd_en = 1'b0;
   logic [7:0] cfg_rd_data;
`endif

   always #5 clk = ~clk;

   contrast_lut_ctrl #(
      .DATA_W (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .per_img_vsync  (per_img_vsync),
      .per_img_href   (per_img_href),
      .per_img_gray   (per_img_gray),
      .cfg_wr_en      (cfg_wr_en),
      .cfg_addr       (cfg_addr),
      .cfg_data       (cfg_data),
      .cfg_commit     (cfg_commit),
`ifdef CONTRAST_LUT_READBACK_EN
      .cfg_rd_en      (cfg_rd_en),
      .cfg_rd_data    (cfg_rd_data),
`endif
      .cfg_busy       (cfg_busy),
      .active_bank    (active_bank),
      .post_img_vsync (post_img_vsync),
      .post_img_href  (post_img_href),
      .post_img_gray  (post_img_gray)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: two curves, which one is live, whether a swap is owed,
   // and how many identity-fill cycles remain.
   logic [7:0] m_curve [2][256];
   bit         m_act;
   bit         m_prev_vs;
   bit         m_pending;
   bit         m_init;
   int         m_init_left;

   typedef struct {
      bit         vs;
      bit         hs;
      logic [7:0] g;
      bit         chk_g;
   } exp_t;

   exp_t q[$];
   exp_t mon_e;
   bit   exp_busy;
   bit   exp_act;
   bit   mon_en = 1'b0;

   task automatic model_reset();
      exp_t z;
      z.vs = 0; z.hs = 0; z.g = 8'h00; z.chk_g = 1;
      m_act = 0; m_prev_vs = 0; m_pending = 0; m_init = 1; m_init_left = 256;
      q.delete();
      q.push_back(z);
      q.push_back(z);
   endtask

   // Drive one cycle of inputs and advance the model by the cycle they occupy.
   task automatic apply(input bit vs, input bit hs, input logic [7:0] g, input bit wr,
                        input logic [7:0] a, input logic [7:0] d, input bit cm);
      exp_t e;
      bit   was_init;
      per_img_vsync = vs; per_img_href = hs; per_img_gray = g;
      cfg_wr_en = wr; cfg_addr = a; cfg_data = d; cfg_commit = cm;
      exp_busy = m_init || m_pending;
      exp_act  = m_act;
      was_init = m_init;
      if (m_init) begin
         m_init_left--;
         if (m_init_left == 0) begin
            m_init = 0;
            for (int i = 0; i < 256; i++) begin
               m_curve[0][i] = 8'(i);
               m_curve[1][i] = 8'(i);
            end
         end
      end else if (!m_pending) begin
         if (wr) m_curve[!m_act][a] = d;
         if (cm) m_pending = 1;
      end else if (vs && !m_prev_vs) begin
         m_act     = !m_act;
         m_pending = 0;
      end
      e.vs = vs;
      e.hs = hs;
      e.g  = hs ? m_curve[m_act][g] : 8'h00;
      e.chk_g = !was_init || !hs;
      q.push_back(e);
      m_prev_vs = vs;
   endtask

   task automatic step(input bit vs, input bit hs, input logic [7:0] g, input bit wr,
                       input logic [7:0] a, input logic [7:0] d, input bit cm);
      @(posedge clk);
      #1;
      apply(vs, hs, g, wr, a, d, cm);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 8'($urandom), 0, 8'h00, 8'h00, 0);
   endtask

   // Stream monitor: outputs equal the model's view of the inputs two cycles ago.
   always @(negedge clk) begin
      if (mon_en && rst_n && q.size() > 2) begin
         mon_e = q.pop_front();
         checks++;
         if (post_img_vsync !== mon_e.vs || post_img_href !== mon_e.hs ||
             (mon_e.chk_g && post_img_gray !== mon_e.g)) begin
            failures++;
            $display("FAIL stream t=%0t: got vs=%0b hs=%0b g=%02h expected vs=%0b hs=%0b g=%02h (checked=%0b)",
                     $time, post_img_vsync, post_img_href, post_img_gray,
                     mon_e.vs, mon_e.hs, mon_e.g, mon_e.chk_g);
         end
         checks++;
         if (cfg_busy !== exp_busy || active_bank !== exp_act) begin
            failures++;
            $display("FAIL status t=%0t: got busy=%0b bank=%0b expected busy=%0b bank=%0b",
                     $time, cfg_busy, active_bank, exp_busy, exp_act);
         end
      end
   end

   // One video frame: vsync lead-in, lines of pixels with random blanking,
   // vsync trailer. mode 0 random, 1 ramp from 0, 2 constant val.
   task automatic frame(input int lines, input int ppl, input int mode,
                        input logic [7:0] val, input int commit_at);
      int         n = 0;
      logic [7:0] ramp = 8'h00;
      logic [7:0] px;
      for (int i = 0; i < 2; i++) begin step(1, 0, 8'($urandom), 0, 8'h00, 8'h00, n == commit_at); n++; end
      for (int l = 0; l < lines; l++) begin
         for (int p = 0; p < ppl; p++) begin
            px = (mode == 0) ? 8'($urandom) : (mode == 1) ? ramp : val;
            ramp++;
            step(1, 1, px, 0, 8'h00, 8'h00, n == commit_at);
            n++;
         end
         for (int gp = 0; gp < int'($urandom_range(1, 3)); gp++) begin
            step(1, 0, 8'($urandom), 0, 8'h00, 8'h00, n == commit_at);
            n++;
         end
      end
      for (int i = 0; i < 3; i++) step(0, 0, 8'($urandom), 0, 8'h00, 8'h00, 0);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3;
      mon_en = 0;
      rst_n  = 0;
      #1;
      checks++;
      if (post_img_vsync !== 1'b0 || post_img_href !== 1'b0 || post_img_gray !== 8'h00 ||
          cfg_busy !== 1'b1 || active_bank !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: got vs=%0b hs=%0b g=%02h busy=%0b bank=%0b expected 0 0 00 1 0",
                  post_img_vsync, post_img_href, post_img_gray, cfg_busy, active_bank);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
      mon_en = 1;
      apply(0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_init();
      for (int i = 0; i < 255; i++) begin
         // commit + write during INIT must be ignored
         if (i == 100) step(0, 0, 8'h00, 1, 8'h40, 8'hAA, 1);
         else          step(0, 0, 8'($urandom), 0, 8'h00, 8'h00, 0);
      end
      checks++;
      if (cfg_busy !== 1'b1) begin
         failures++;
         $display("FAIL init_busy_255: got %0b expected 1", cfg_busy);
      end
      step(0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
      checks++;
      if (cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL init_busy_256: got %0b expected 0", cfg_busy);
      end
      frame(4, 4, 1, 8'h00, -1);
   endtask

   task automatic test_inverse_commit();
      for (int i = 0; i < 256; i++) step(0, 0, 8'h00, 1, 8'(i), 8'(255 - i), 0);
      step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
      idle(3);
      checks++;
      if (cfg_busy !== 1'b1 || active_bank !== 1'b0) begin
         failures++;
         $display("FAIL pending_wait: got busy=%0b bank=%0b expected busy=1 bank=0", cfg_busy, active_bank);
      end
      frame(4, 4, 2, 8'h10, -1);
      checks++;
      if (active_bank !== 1'b1 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL swap_to_1: got busy=%0b bank=%0b expected busy=0 bank=1", cfg_busy, active_bank);
      end
   endtask

   task automatic test_midframe_commit();
      // Swap back to identity so the inverse curve sits in the shadow bank.
      step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
      frame(1, 4, 0, 8'h00, -1);
      frame(3, 4, 2, 8'h20, 5);
      checks++;
      if (active_bank !== 1'b0 || cfg_busy !== 1'b1) begin
         failures++;
         $display("FAIL midframe_hold: got busy=%0b bank=%0b expected busy=1 bank=0", cfg_busy, active_bank);
      end
      frame(3, 4, 2, 8'h20, -1);
      checks++;
      if (active_bank !== 1'b1) begin
         failures++;
         $display("FAIL midframe_swap: got bank=%0b expected 1", active_bank);
      end
   endtask

   task automatic test_same_cycle_write_commit();
      step(0, 0, 8'h00, 1, 8'h05, 8'h80, 1);
      frame(2, 3, 2, 8'h05, -1);
      checks++;
      if (active_bank !== 1'b0) begin
         failures++;
         $display("FAIL same_cycle_swap: got bank=%0b expected 0", active_bank);
      end
   endtask

   task automatic test_pending_write();
      step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
      step(0, 0, 8'h00, 1, 8'h07, 8'h00, 0);
      step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
      frame(2, 4, 2, 8'h07, -1);
      checks++;
      if (active_bank !== 1'b1) begin
         failures++;
         $display("FAIL pending_swap: got bank=%0b expected 1", active_bank);
      end
      frame(1, 4, 2, 8'h07, -1);
      checks++;
      if (active_bank !== 1'b1 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL no_queued_commit: got busy=%0b bank=%0b expected busy=0 bank=1", cfg_busy, active_bank);
      end
   endtask

`ifdef CONTRAST_LUT_READBACK_EN
   task automatic test_readback();
      logic [7:0] old_v;
      old_v = m_curve[!m_act][8'h33];
      cfg_rd_en = 1;
      step(0, 0, 8'h00, 1, 8'h33, 8'h5A, 0);
      step(0, 0, 8'h00, 0, 8'h33, 8'h00, 0);
      checks++;
      if (cfg_rd_data !== old_v) begin
         failures++;
         $display("FAIL readback_old: got %02h expected %02h", cfg_rd_data, old_v);
      end
      cfg_rd_en = 0;
      step(0, 0, 8'h00, 0, 8'h00, 8'h00, 0);
      checks++;
      if (cfg_rd_data !== 8'h5A) begin
         failures++;
         $display("FAIL readback_new: got %02h expected 5a", cfg_rd_data);
      end
      idle(2);
      checks++;
      if (cfg_rd_data !== 8'h5A) begin
         failures++;
         $display("FAIL readback_hold: got %02h expected 5a", cfg_rd_data);
      end
   endtask
`endif

   task automatic test_random_curves();
      for (int it = 0; it < 3; it++) begin
         for (int w = 0; w < 40; w++)
            step(0, 1'($urandom), 8'($urandom), 1, 8'($urandom), 8'($urandom), 0);
         if (it == 1) begin
            frame(int'($urandom_range(2, 4)), int'($urandom_range(3, 6)), 0, 8'h00, 4);
         end else begin
            step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
         end
         frame(int'($urandom_range(2, 4)), int'($urandom_range(3, 6)), 0, 8'h00, -1);
         frame(2, 5, 0, 8'h00, -1);
      end
   endtask

   task automatic test_reset_pending();
      if (!m_act) begin
         step(0, 0, 8'h00, 0, 8'h00, 8'h00, 1);
         frame(1, 2, 0, 8'h00, -1);
      end
      step(1, 0, 8'h00, 0, 8'h00, 8'h00, 0);
      step(1, 1, 8'h3C, 0, 8'h00, 8'h00, 1);
      for (int i = 0; i < 4; i++) step(1, 1, 8'($urandom), 0, 8'h00, 8'h00, 0);
      checks++;
      if (cfg_busy !== 1'b1 || active_bank !== 1'b1 || post_img_href !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset_state: got busy=%0b bank=%0b href=%0b expected 1 1 1",
                  cfg_busy, active_bank, post_img_href);
      end
      per_img_vsync = 1; per_img_href = 1;
      apply_reset();
      idle(256);
      frame(3, 5, 0, 8'h00, -1);
      checks++;
      if (active_bank !== 1'b0 || cfg_busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset_identity: got busy=%0b bank=%0b expected busy=0 bank=0", cfg_busy, active_bank);
      end
   endtask

   initial begin
      test_reset();
      test_init();
      test_inverse_commit();
      test_midframe_commit();
      test_same_cycle_write_commit();
      test_pending_write();
`ifdef CONTRAST_LUT_READBACK_EN
      test_readback();
`endif
      test_random_curves();
      test_reset_pending();
      idle(3);
      mon_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/contrast_lut_ctrl.md
Name: contrast_lut_ctrl

Overview:
- Owns the gray-level contrast curve used on the vsync/href/gray video stream.
- Holds two 256-entry curve tables (ping-pong banks) and maps each pixel through the active table.
- A host loads a new curve into the shadow bank. The controller swaps banks only at a frame boundary, so no frame ever mixes two curves.
- Sits between the pixel source and the downstream image-processing stage.

Parameters:
- DATA_W, 8, pixel and table-entry width.
- DEPTH, 2**DATA_W, entries per bank. Derived; must not be overridden.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- per_img_vsync  in  1  input frame valid; high for the whole frame.
- per_img_href  in  1  input line/pixel valid.
- per_img_gray  in  DATA_W  input pixel.
- cfg_wr_en  in  1  shadow-bank write strobe.
- cfg_addr  in  DATA_W  shadow-bank write address (input gray level).
- cfg_data  in  DATA_W  shadow-bank write data (output gray level).
- cfg_commit  in  1  one-cycle pulse; requests a bank swap at the next frame start.
- cfg_busy  out  1  high in INIT and PENDING; writes and commits are ignored while high.
- active_bank  out  1  bank currently used for mapping.
- post_img_vsync  out  1  per_img_vsync delayed 2 cycles.
- post_img_href  out  1  per_img_href delayed 2 cycles.
- post_img_gray  out  DATA_W  mapped pixel, aligned with post_img_href.

Behaviour:
- Reset (async, rst_n low):
  - All outputs 0 except cfg_busy=1.
  - active_bank=0; FSM in INIT; delay pipes cleared.
  - Any operation in flight is abandoned, including a pending commit or a partial fill.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 registers gray, vsync and href.
  - Stage 2 registers post_img_gray = bank[active_bank][gray_s1], plus vsync/href.
  - post_img_gray is forced to 0 when the stage-2 href is 0.
- FSM state INIT:
  - An 8-bit counter writes identity (entry i = i) into both banks, one address per cycle, 256 cycles.
  - Video is mapped through bank 0 as it fills. Frames are not blocked.
  - Counter wrap 255->0 moves the FSM to LOAD.
- FSM state LOAD:
  - cfg_busy=0.
  - cfg_wr_en writes cfg_data to the shadow bank (~active_bank) at cfg_addr.
  - cfg_commit moves the FSM to PENDING.
  - cfg_wr_en and cfg_commit in the same cycle: the write completes, then the FSM goes to PENDING.
- FSM state PENDING:
  - cfg_busy=1; writes ignored.
  - On the per_img_vsync rising edge (input side, previous-cycle vsync=0, current=1), active_bank toggles and the FSM returns to LOAD.
  - The first pixel of that frame uses the new bank.
  - Mid-frame commits therefore wait for the next frame.
  - A commit with vsync already high does not swap until vsync falls and rises again.
- After a swap the new shadow bank holds the previous curve. Its contents are not copied; a host doing a partial reload must rewrite every entry it relies on.
- Writes to the active bank are impossible by construction.
- cfg_commit outside LOAD is ignored. No queuing.
- Banks: two DEPTH x DATA_W arrays with one write port and one read port each. The read is synchronous, in stage 2.

Optional Feature:
- Macro: CONTRAST_LUT_READBACK_EN.
- Defined: adds ports cfg_rd_en (in, 1) and cfg_rd_data (out, DATA_W).
  - cfg_rd_en in LOAD returns shadow-bank[cfg_addr] on cfg_rd_data one cycle later.
  - cfg_rd_data resets to 0 and holds its last value otherwise.
  - A same-cycle write and read to the same address returns the old data.
- Undefined: neither port exists and no readback logic is generated.

Decomposition:
- Package contrast_lut_pkg:
  - DATA_W_DEF=8, DEPTH_DEF=256, PIPE_LAT=2.
  - typedef enum logic [1:0] {ST_INIT, ST_LOAD, ST_PENDING} lut_state_e.
  - typedef logic [7:0] gray_t.
- One sub-module, contrast_lut_bank: a single DEPTH x DATA_W synchronous-read RAM.
  - Instantiated twice.
  - Write-port mux (INIT counter vs cfg) and the FSM stay in the top module.

Test Plan:
- Reset release, wait 256 cycles, then send a 4x4 frame of values 0x00..0x0F -> cfg_busy falls at cycle 256; output equals input; post signals lag input by exactly 2 cycles.
- In LOAD, write the inverse curve (entry i = 255-i) and commit between frames, then send a frame with pixel 0x10 -> cfg_busy=1 until vsync rises; active_bank 0->1; output 0xEF.
- Commit mid-frame (vsync high, pixel 0x20) -> remaining pixels of that frame map to 0x20; next frame maps to 0xDF; swap happens exactly on that frame's vsync rise.
- Write to address 0x05 and commit in the same cycle with data 0x80, then send pixel 0x05 next frame -> output 0x80.
- Write with cfg_wr_en during PENDING (addr 0x07, data 0x00) after a swap -> entry 0x07 of the new shadow bank is unchanged, checked through a swap back (expect the previous curve's value) or via readback.
- Assert rst_n low mid-frame during PENDING -> outputs go to 0 immediately; active_bank=0; FSM in INIT; after 256 cycles identity mapping is restored.
